// File: rtl/ship_ctrl_pkg.sv
// Shared constants and state encoding for the starflux ship controller.
package ship_ctrl_pkg;

  localparam int DEF_SCREEN_W    = 160;
  localparam int DEF_SCREEN_H    = 120;
  localparam int DEF_X_BITS      = 8;
  localparam int DEF_Y_BITS      = 7;
  localparam int DEF_COLOUR_BITS = 3;

  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DRAW   = 2'd3
  } ship_state_t;

  function automatic logic is_scan_state(input ship_state_t s);
    return (s == ST_ERASE) || (s == ST_DRAW);
  endfunction

endpackage

// File: rtl/ship_ctrl_if.sv
// Pixel-plot bus towards the VGA adapter mux.
interface ship_ctrl_if #(
  parameter int X_BITS      = ship_ctrl_pkg::DEF_X_BITS,
  parameter int Y_BITS      = ship_ctrl_pkg::DEF_Y_BITS,
  parameter int COLOUR_BITS = ship_ctrl_pkg::DEF_COLOUR_BITS
);
  logic [X_BITS-1:0]      x;
  logic [Y_BITS-1:0]      y;
  logic [COLOUR_BITS-1:0] colour;
  logic                   plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/ship_ctrl_sprite_scan_counter.sv
// Raster walk over a W x H sprite footprint; dx fastest, dy slower.
// Runs while start is held and clears itself whenever start drops or the last pixel is reached.
module sprite_scan_counter #(
  parameter int W = 8,
  parameter int H = 4,
  localparam int DX_W = (W > 1) ? $clog2(W) : 1,
  localparam int DY_W = (H > 1) ? $clog2(H) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic            active,
  output logic            done
);

  logic last_x;
  logic last_y;

  assign last_x = (dx == DX_W'(W - 1));
  assign last_y = (dy == DY_W'(H - 1));
  assign active = start;
  assign done   = start && last_x && last_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx <= '0;
      dy <= '0;
    end else if (!start || done) begin
      dx <= '0;
      dy <= '0;
    end else if (last_x) begin
      dx <= '0;
      dy <= dy + 1'b1;
    end else begin
      dx <= dx + 1'b1;
    end
  end

endmodule

// File: rtl/ship_ctrl.sv
// Ship horizontal movement with erase/redraw through the VGA pixel-plot bus.
//   state  | meaning
//   IDLE   | waiting for a movement tick with a useful key combination
//   ERASE  | painting BG_COLOUR over the old footprint
//   UPDATE | one-cycle commit of the new ship_x
//   DRAW   | painting SHIP_COLOUR at ship_x (also the reset state)
module ship_ctrl
  import ship_ctrl_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int X_BITS      = DEF_X_BITS,
  parameter int Y_BITS      = DEF_Y_BITS,
  parameter int COLOUR_BITS = DEF_COLOUR_BITS,
  parameter int SHIP_W      = 8,
  parameter int SHIP_H      = 4,
  parameter int SHIP_Y      = 112,
  parameter int STEP        = 2,
  parameter int TICK_CYCLES = 833333,
  parameter int WRAP_EN     = 0,
  parameter logic [COLOUR_BITS-1:0] SHIP_COLOUR = COLOUR_BITS'(COLOUR_WHITE),
  parameter logic [COLOUR_BITS-1:0] BG_COLOUR   = COLOUR_BITS'(COLOUR_BLACK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left_key,
  input  logic               right_key,
  ship_ctrl_if.master        pix,
  output logic               busy,
  output logic [X_BITS-1:0]  ship_x
);

  localparam int DX_W   = (SHIP_W > 1) ? $clog2(SHIP_W) : 1;
  localparam int DY_W   = (SHIP_H > 1) ? $clog2(SHIP_H) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // Keep the sprite fully on screen even if SHIP_Y is set too low.
  localparam int Y_TOP  = (SHIP_Y + SHIP_H > SCREEN_H) ? (SCREEN_H - SHIP_H) : SHIP_Y;

  localparam logic signed [X_BITS:0] STEP_S = (X_BITS + 1)'(STEP);
  localparam logic signed [X_BITS:0] SCR_S  = (X_BITS + 1)'(SCREEN_W);
  localparam logic signed [X_BITS:0] XMAX_S = (X_BITS + 1)'(SCREEN_W - SHIP_W);

  ship_state_t state, state_nxt;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [X_BITS-1:0] nx;
  logic [X_BITS-1:0] nx_q;
  logic signed [X_BITS:0] sx;
  logic [X_BITS:0]   px_sum;
  logic [X_BITS-1:0] px;
  logic [Y_BITS-1:0] py;
  logic [DX_W-1:0]   dx;
  logic [DY_W-1:0]   dy;
  logic              scan_run;
  logic              scan_active;
  logic              scan_done;

  assign tick     = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign scan_run = is_scan_state(state);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  sprite_scan_counter #(.W(SHIP_W), .H(SHIP_H)) u_scan (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_run),
    .dx     (dx),
    .dy     (dy),
    .active (scan_active),
    .done   (scan_done)
  );

  // Signed with one spare bit so moving left from column 0 goes negative instead of wrapping.
  always_comb begin
    sx = $signed({1'b0, ship_x});
    if (left_key && !right_key) sx = sx - STEP_S;
    else if (right_key && !left_key) sx = sx + STEP_S;
    nx = ship_x;
    if (WRAP_EN != 0) begin
      if (sx[X_BITS]) nx = X_BITS'(sx + SCR_S);
      else if (sx >= SCR_S) nx = X_BITS'(sx - SCR_S);
      else nx = X_BITS'(sx);
    end else begin
      if (sx[X_BITS]) nx = '0;
      else if (sx > XMAX_S) nx = X_BITS'(XMAX_S);
      else nx = X_BITS'(sx);
    end
  end

  always_comb begin
    px_sum = {1'b0, ship_x} + (X_BITS + 1)'(dx);
    if ((WRAP_EN != 0) && (px_sum >= (X_BITS + 1)'(SCREEN_W)))
      px_sum = px_sum - (X_BITS + 1)'(SCREEN_W);
    px = px_sum[X_BITS-1:0];
    py = Y_BITS'(Y_TOP) + Y_BITS'(dy);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick && (nx != ship_x)) state_nxt = ST_ERASE;
      ST_ERASE:  if (scan_done) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_DRAW;
      ST_DRAW:   if (scan_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_DRAW;
      ship_x <= X_BITS'((SCREEN_W - SHIP_W) / 2);
      nx_q   <= X_BITS'((SCREEN_W - SHIP_W) / 2);
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && tick) nx_q <= nx;
      if (state == ST_UPDATE) ship_x <= nx_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix.x      <= '0;
      pix.y      <= '0;
      pix.colour <= '0;
      pix.plot   <= 1'b0;
    end else begin
      pix.plot <= scan_active;
      if (scan_active) begin
        pix.x      <= px;
        pix.y      <= py;
        pix.colour <= (state == ST_ERASE) ? BG_COLOUR : SHIP_COLOUR;
      end else begin
        pix.x      <= '0;
        pix.y      <= '0;
        pix.colour <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ship_ctrl.sv
// Directed bench for ship_ctrl: one clamp-mode and one wrap-mode instance, fast tick.
module tb_ship_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic left_c = 1'b0, right_c = 1'b0, left_w = 1'b0, right_w = 1'b0;
  logic busy_c, busy_w;
  logic [7:0] ship_x_c, ship_x_w;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {int x; int y; int c; int t;} pix_t;
  pix_t log_c[$];
  pix_t log_w[$];

  ship_ctrl_if #(.X_BITS(8), .Y_BITS(7), .COLOUR_BITS(3)) pix_c ();
  ship_ctrl_if #(.X_BITS(8), .Y_BITS(7), .COLOUR_BITS(3)) pix_w ();

  ship_ctrl #(.TICK_CYCLES(4), .WRAP_EN(0)) dut_c (
    .clk(clk), .reset(reset), .left_key(left_c), .right_key(right_c),
    .pix(pix_c), .busy(busy_c), .ship_x(ship_x_c)
  );

  ship_ctrl #(.TICK_CYCLES(4), .WRAP_EN(1)) dut_w (
    .clk(clk), .reset(reset), .left_key(left_w), .right_key(right_w),
    .pix(pix_w), .busy(busy_w), .ship_x(ship_x_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pix_c.plot) log_c.push_back('{x: int'(pix_c.x), y: int'(pix_c.y), c: int'(pix_c.colour), t: cyc});
    if (pix_w.plot) log_w.push_back('{x: int'(pix_w.x), y: int'(pix_w.y), c: int'(pix_w.colour), t: cyc});
  end

  initial begin
    #600us;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pk(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic busy_of(input bit w);
    return w ? busy_w : busy_c;
  endfunction

  task automatic set_keys(input bit w, input logic l, input logic r);
    if (w) begin
      left_w = l; right_w = r;
    end else begin
      left_c = l; right_c = r;
    end
  endtask

  task automatic wait_idle(input bit w, input string tag);
    int n = 0;
    while (busy_of(w) && n < 300) begin
      nclk(1);
      n++;
    end
    if (busy_of(w)) chk({tag, "_idle_timeout"}, 1, 0);
  endtask

  // Hold the keys until the move starts, then release so exactly one move happens.
  task automatic move_once(input bit w, input logic l, input logic r, input string tag);
    int n = 0;
    set_keys(w, l, r);
    while (!busy_of(w) && n < 20) begin
      nclk(1);
      n++;
    end
    set_keys(w, 1'b0, 1'b0);
    if (!busy_of(w)) chk({tag, "_start_timeout"}, 0, 1);
    wait_idle(w, tag);
  endtask

  initial begin
    int n;
    logic saw;

    nclk(3);
    chk("rst_plot",   int'(pix_c.plot),   0);
    chk("rst_busy",   int'(busy_c),       1);
    chk("rst_ship_x", int'(ship_x_c),     76);
    chk("rst_x",      int'(pix_c.x),      0);
    chk("rst_y",      int'(pix_c.y),      0);
    chk("rst_colour", int'(pix_c.colour), 0);

    reset = 1'b1;
    wait_idle(0, "init");
    wait_idle(1, "init_w");
    chk("init_count", log_c.size(), 32);
    if (log_c.size() == 32) begin
      for (int i = 0; i < 32; i++)
        chk("init_px", pk(log_c[i].x, log_c[i].y, log_c[i].c), pk(76 + i % 8, 112 + i / 8, 7));
      chk("init_span", log_c[31].t - log_c[0].t, 31);
    end
    chk("init_ship_x", int'(ship_x_c), 76);
    chk("init_count_w", log_w.size(), 32);

    log_c.delete();
    move_once(0, 1'b0, 1'b1, "right");
    chk("right_count", log_c.size(), 64);
    if (log_c.size() == 64) begin
      for (int i = 0; i < 32; i++)
        chk("right_erase_px", pk(log_c[i].x, log_c[i].y, log_c[i].c), pk(76 + i % 8, 112 + i / 8, 0));
      for (int i = 0; i < 32; i++)
        chk("right_draw_px", pk(log_c[32 + i].x, log_c[32 + i].y, log_c[32 + i].c),
            pk(78 + i % 8, 112 + i / 8, 7));
      chk("right_gap", log_c[32].t - log_c[31].t, 2);
    end
    chk("right_ship_x", int'(ship_x_c), 78);

    log_c.delete();
    left_c = 1'b1; right_c = 1'b1;
    saw = 1'b0;
    repeat (24) begin
      nclk(1);
      if (busy_c) saw = 1'b1;
    end
    left_c = 1'b0; right_c = 1'b0;
    chk("both_plots",  log_c.size(), 0);
    chk("both_busy",   int'(saw),    0);
    chk("both_ship_x", int'(ship_x_c), 78);

    for (int i = 0; i < 60 && ship_x_c != 8'd152; i++) move_once(0, 1'b0, 1'b1, "to_right");
    chk("reach_right", int'(ship_x_c), 152);
    log_c.delete();
    right_c = 1'b1;
    nclk(40);
    right_c = 1'b0;
    chk("clamp_r_plots",  log_c.size(), 0);
    chk("clamp_r_ship_x", int'(ship_x_c), 152);

    for (int i = 0; i < 120 && ship_x_c != 8'd0; i++) move_once(0, 1'b1, 1'b0, "to_left");
    chk("reach_left", int'(ship_x_c), 0);
    log_c.delete();
    left_c = 1'b1;
    nclk(40);
    left_c = 1'b0;
    chk("clamp_l_plots",  log_c.size(), 0);
    chk("clamp_l_ship_x", int'(ship_x_c), 0);

    for (int i = 0; i < 60 && ship_x_w != 8'd0; i++) move_once(1, 1'b1, 1'b0, "wrap_to_left");
    chk("wrap_reach_left", int'(ship_x_w), 0);
    log_w.delete();
    move_once(1, 1'b1, 1'b0, "wrap");
    chk("wrap_ship_x", int'(ship_x_w), 158);
    chk("wrap_count", log_w.size(), 64);
    if (log_w.size() == 64) begin
      for (int j = 0; j < 8; j++) chk("wrap_erase_x", log_w[j].x, j);
      for (int j = 0; j < 8; j++)
        chk("wrap_draw_px", pk(log_w[32 + j].x, log_w[32 + j].y, log_w[32 + j].c),
            pk((158 + j) % 160, 112, 7));
    end

    log_c.delete();
    right_c = 1'b1;
    n = 0;
    while (log_c.size() < 10 && n < 100) begin
      nclk(1);
      n++;
    end
    right_c = 1'b0;
    chk("mid_plots_seen", log_c.size(), 10);
    reset = 1'b0;
    #1;
    chk("mid_plot",   int'(pix_c.plot), 0);
    chk("mid_busy",   int'(busy_c),     1);
    chk("mid_ship_x", int'(ship_x_c),   76);
    nclk(2);
    log_c.delete();
    reset = 1'b1;
    wait_idle(0, "mid_redraw");
    chk("mid_count", log_c.size(), 32);
    if (log_c.size() == 32) begin
      chk("mid_first_px", pk(log_c[0].x, log_c[0].y, log_c[0].c),    pk(76, 112, 7));
      chk("mid_last_px",  pk(log_c[31].x, log_c[31].y, log_c[31].c), pk(83, 115, 7));
    end
    chk("mid_final_ship_x", int'(ship_x_c), 76);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
